// File: rtl/leading_zeros_pad.sv
// rtl/leading_zeros_pad.sv - sequential zero-padding right shifter with valid/ready handshake
module leading_zeros_pad #(
    parameter int SIZE = 8,
    parameter int CW   = $clog2(SIZE)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [SIZE-1:0] in_data_i,
    input  logic [CW-1:0]   in_zeros_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [SIZE-1:0] out_data_o,
    output logic            out_lost_o,
    output logic            busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [SIZE-1:0] data_q, data_d;
    logic [CW-1:0]   rem_q, rem_d;
    logic            lost_q, lost_d;
    logic            accept;

    assign accept = (state_q == ST_IDLE) && in_valid_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            rem_q   <= '0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            lost_q  <= lost_d;
        end
    end

    // A counter of one (or an impossible zero) ends the shift phase on this edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid_i) begin
                    state_d = (in_zeros_i == '0) ? ST_HOLD : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (rem_q <= CW'(1)) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        data_d = data_q;
        rem_d  = rem_q;
        lost_d = lost_q;
        if (accept) begin
            data_d = in_data_i;
            rem_d  = in_zeros_i;
            lost_d = 1'b0;
        end else if (state_q == ST_SHIFT) begin
            data_d = {1'b0, data_q[SIZE-1:1]};
            lost_d = lost_q | data_q[0];
            if (rem_q != '0) begin
                rem_d = rem_q - CW'(1);
            end
        end
    end

    always_comb begin
        in_ready_o  = (state_q == ST_IDLE);
        out_valid_o = (state_q == ST_HOLD);
        busy_o      = (state_q != ST_IDLE);
        out_data_o  = data_q;
        out_lost_o  = lost_q;
    end

endmodule

// File: tb/tb_leading_zeros_pad.sv
// tb/tb_leading_zeros_pad.sv - scoreboard bench for leading_zeros_pad
module tb_leading_zeros_pad;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic [2:0] in_zeros = 3'd0;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_lost;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit rand_ready = 1'b0;
    bit ready_level = 1'b1;

    typedef struct {
        logic [7:0] data;
        logic       lost;
        int         lat;
        int         acc_cyc;
    } exp_t;
    exp_t sb[$];

    leading_zeros_pad #(.SIZE(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_data_i(in_data), .in_zeros_i(in_zeros),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_data_o(out_data), .out_lost_o(out_lost),
        .busy_o(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares the head of the scoreboard whenever a result is presented.
    bit         in_hold = 1'b0;
    bit         was_pop = 1'b0;
    logic [7:0] held_data;
    logic       held_lost;
    always @(negedge clk) begin
        if (rst) begin
            in_hold = 1'b0;
            was_pop = 1'b0;
        end else begin
            if (was_pop) begin
                chk("idle_after_hold", {in_ready, out_valid, busy}, 3'b100);
                was_pop = 1'b0;
            end
            if (out_valid) begin
                chk("ready_low_in_hold", in_ready, 0);
                if (sb.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else if (!in_hold) begin
                    in_hold = 1'b1;
                    held_data = out_data;
                    held_lost = out_lost;
                    chk("out_data", out_data, sb[0].data);
                    chk("out_lost", out_lost, sb[0].lost);
                    chk("latency", cyc - sb[0].acc_cyc, sb[0].lat);
                end else begin
                    chk("hold_data_stable", out_data, held_data);
                    chk("hold_lost_stable", out_lost, held_lost);
                end
                if (out_ready && sb.size() != 0) begin
                    void'(sb.pop_front());
                    in_hold = 1'b0;
                    was_pop = 1'b1;
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic [2:0] z,
                        input logic [7:0] ed, input logic el);
        int t;
        exp_t e;
        t = 0;
        @(posedge clk); #1;
        in_data = d; in_zeros = z; in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 200) begin
                chk("accept_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
        end
        e.data = ed; e.lost = el; e.lat = int'(z) + 1; e.acc_cyc = cyc;
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data = 8'($urandom);
        in_zeros = 3'($urandom);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 || out_valid) begin
            @(negedge clk);
            t++;
            if (t > 500) begin
                chk("drain_timeout", 0, 1);
                return;
            end
        end
    endtask

    initial begin
        logic [7:0] d, m;
        logic [2:0] z;

        // Reset with a pending request: nothing may be accepted.
        in_valid = 1'b1; in_data = 8'h5A; in_zeros = 3'd2;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_out_lost", out_lost, 0);
        chk("rst_busy", busy, 0);
        in_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);

        send(8'hA5, 3'd0, 8'hA5, 1'b0);
        drain();
        send(8'hB1, 3'd3, 8'h16, 1'b1);
        send(8'h80, 3'd7, 8'h01, 1'b0);
        drain();

        // Backpressure: hold result for 5 cycles.
        ready_level = 1'b0;
        send(8'hF0, 3'd2, 8'h3C, 1'b0);
        while (!out_valid) @(negedge clk);
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
        end
        ready_level = 1'b1;
        drain();

        // Reset in the third shift cycle discards the transaction.
        send(8'hFF, 3'd5, 8'h07, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_data", out_data, 8'h00);
        chk("mid_rst_out_lost", out_lost, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_busy", busy, 0);
        send(8'h40, 3'd1, 8'h20, 1'b0);
        drain();

        // Randomised traffic with random backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            d = 8'($urandom);
            z = 3'($urandom);
            m = 8'((1 << z) - 1);
            send(d, z, d >> z, |(d & m));
        end
        drain();
        rand_ready = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
